// File: rtl/btn_event_sched.sv
// Button-event scheduler: shared debounce sample tick, per-button PRESS/LONG/REPEAT
// generation, and a round-robin arbiter driving a single valid/ready event port.
module btn_event_sched #(
  parameter int unsigned BTN_WIDTH    = 8,
  parameter bit          BTN_ACT_LOW  = 1'b1,
  parameter int unsigned TICK_CYC     = 540000,
  parameter int unsigned LONG_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10,
  parameter int unsigned ID_W         = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BTN_WIDTH-1:0] btn_deb,
  output logic                 sample_tick,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [ID_W-1:0]      evt_id,
  output logic [1:0]           evt_type,
  output logic                 evt_ovf
);

  localparam int unsigned CNT_W = (TICK_CYC > 2) ? $clog2(TICK_CYC) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} state_e;

  localparam logic [1:0] EVT_PRESS  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_REPEAT = 2'b11;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BTN_WIDTH-1:0] hist_q, pressed, edge_v;
  state_e               state_q [BTN_WIDTH];
  state_e               state_d [BTN_WIDTH];
  logic [7:0]           hc_q    [BTN_WIDTH];
  logic [7:0]           hc_d    [BTN_WIDTH];
  logic [BTN_WIDTH-1:0] post, pend_v_q, pend_v_d;
  logic [1:0]           post_type [BTN_WIDTH];
  logic [1:0]           pend_t_q  [BTN_WIDTH];
  logic [1:0]           pend_t_d  [BTN_WIDTH];
  logic [ID_W-1:0]      rr_q, rr_d, gnt_id, evt_id_q, evt_id_d;
  logic [1:0]           evt_type_q, evt_type_d;
  logic                 gnt_v, load, evt_valid_q, evt_valid_d, evt_ovf_q, evt_ovf_d, tick;

  // Index base+off folded back into 0..BTN_WIDTH-1 (BTN_WIDTH need not be a power of two).
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int unsigned off);
    logic [ID_W:0] s;
    s = {1'b0, base} + (ID_W+1)'(off);
    if (s >= (ID_W+1)'(BTN_WIDTH)) s = s - (ID_W+1)'(BTN_WIDTH);
    return s[ID_W-1:0];
  endfunction

  // NOTE: every signal assigned in this block gets a default first, so no latches are inferred.
  always_comb begin
    tick    = (cnt_q == CNT_W'(TICK_CYC - 1));
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    pressed = btn_deb ^ {BTN_WIDTH{BTN_ACT_LOW}};
    edge_v  = pressed & ~hist_q;

    for (int i = 0; i < BTN_WIDTH; i++) begin
      state_d[i]   = state_q[i];
      hc_d[i]      = hc_q[i];
      post[i]      = 1'b0;
      post_type[i] = EVT_PRESS;
      if (!pressed[i]) begin
        state_d[i] = ST_IDLE;
        hc_d[i]    = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: if (edge_v[i]) begin
            state_d[i] = ST_HELD;
            hc_d[i]    = '0;
            post[i]    = 1'b1;
          end
          ST_HELD: if (tick) begin
            if (hc_q[i] + 8'd1 == 8'(LONG_TICKS)) begin
              state_d[i]   = ST_LONG;
              hc_d[i]      = '0;
              post[i]      = 1'b1;
              post_type[i] = EVT_LONG;
            end else hc_d[i] = hc_q[i] + 8'd1;
          end
          ST_LONG: if (tick) begin
            if (hc_q[i] + 8'd1 == 8'(REPEAT_TICKS)) begin
              hc_d[i]      = '0;
              post[i]      = 1'b1;
              post_type[i] = EVT_REPEAT;
            end else hc_d[i] = hc_q[i] + 8'd1;
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end

    // Descending scan so the slot closest to rr (smallest offset) wins.
    gnt_v  = 1'b0;
    gnt_id = '0;
    for (int k = BTN_WIDTH - 1; k >= 0; k--) begin
      if (pend_v_q[wrap_idx(rr_q, k)]) begin
        gnt_v  = 1'b1;
        gnt_id = wrap_idx(rr_q, k);
      end
    end

    load        = !evt_valid_q || evt_ready;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_type_d  = evt_type_q;
    rr_d        = rr_q;
    if (load) begin
      evt_valid_d = gnt_v;
      if (gnt_v) begin
        evt_id_d   = gnt_id;
        evt_type_d = pend_t_q[gnt_id];
        rr_d       = wrap_idx(gnt_id, 1);
      end
    end

    // A post wins over a same-cycle grant of its slot: the old event leaves, the new one stays.
    evt_ovf_d = 1'b0;
    for (int i = 0; i < BTN_WIDTH; i++) begin
      pend_v_d[i] = pend_v_q[i];
      pend_t_d[i] = pend_t_q[i];
      if (post[i]) begin
        if (pend_v_q[i] && !(load && gnt_v && gnt_id == ID_W'(i))) evt_ovf_d = 1'b1;
        pend_v_d[i] = 1'b1;
        pend_t_d[i] = post_type[i];
      end else if (load && gnt_v && gnt_id == ID_W'(i)) begin
        pend_v_d[i] = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      hist_q      <= '0;
      pend_v_q    <= '0;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_type_q  <= '0;
      evt_ovf_q   <= 1'b0;
      // NOTE: the per-button arrays are reset too; a stale slot or FSM would leak events after reset.
      for (int i = 0; i < BTN_WIDTH; i++) begin
        state_q[i]  <= ST_IDLE;
        hc_q[i]     <= '0;
        pend_t_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      hist_q      <= pressed;
      pend_v_q    <= pend_v_d;
      rr_q        <= rr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_type_q  <= evt_type_d;
      evt_ovf_q   <= evt_ovf_d;
      for (int i = 0; i < BTN_WIDTH; i++) begin
        state_q[i]  <= state_d[i];
        hc_q[i]     <= hc_d[i];
        pend_t_q[i] <= pend_t_d[i];
      end
    end
  end

  assign sample_tick = tick;
  assign evt_valid   = evt_valid_q;
  assign evt_id      = evt_id_q;
  assign evt_type    = evt_type_q;
  assign evt_ovf     = evt_ovf_q;

endmodule

// File: tb/tb_btn_event_sched.sv
// Directed bench for btn_event_sched with short tick/hold parameters (active-high buttons).
module tb_btn_event_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] btn_deb = '0;
  logic       sample_tick, evt_valid, evt_ready, evt_ovf;
  logic [2:0] evt_id;
  logic [1:0] evt_type;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  logic [4:0] ev_q[$];
  int         ts_q[$];

  btn_event_sched #(
    .BTN_WIDTH(8), .BTN_ACT_LOW(1'b0), .TICK_CYC(10),
    .LONG_TICKS(3), .REPEAT_TICKS(2), .ID_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_deb(btn_deb), .sample_tick(sample_tick),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_type(evt_type), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake observer: valid&&ready seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      ev_q.push_back({evt_id, evt_type});
      ts_q.push_back(cyc);
    end
    if (rst_n && evt_ovf) ovf_cnt <= ovf_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic exp_tick;
    evt_ready = 1'b0;
    btn_deb   = '0;
    rst_n     = 1'b0;
    step(3);
    checks++;
    if ({sample_tick, evt_valid, evt_ovf} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=000", {sample_tick, evt_valid, evt_ovf});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int n = 1; n <= 35; n++) begin
      step(1);
      exp_tick = ((n + 1) % 10 == 0);  // pulse is consumed by rising edges 10, 20, 30
      checks++;
      if (sample_tick !== exp_tick) begin
        failures++;
        $display("FAIL tick_edge%0d got=%b want=%b", n, sample_tick, exp_tick);
      end
      checks++;
      if ({evt_valid, evt_ovf} !== 2'b00) begin
        failures++;
        $display("FAIL idle_outputs_edge%0d got=%b want=00", n, {evt_valid, evt_ovf});
      end
    end
  endtask

  task automatic test_press_latency;
    evt_ready  = 1'b1;
    btn_deb[2] = 1'b1;
    step(1);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_e0 valid got=%b want=0", evt_valid);
    end
    step(1);
    checks++;
    if ({evt_valid, evt_id, evt_type} !== {1'b1, 3'd2, 2'b01}) begin
      failures++;
      $display("FAIL latency_e1 got=v%b id%0d t%b want=v1 id2 t01", evt_valid, evt_id, evt_type);
    end
    step(1);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_event valid got=%b want=0", evt_valid);
    end
    btn_deb = '0;
    step(3);
  endtask

  task automatic test_long_repeat;
    int base, after;
    logic [4:0] exp_ev [5];
    exp_ev = '{5'b000_01, 5'b000_10, 5'b000_11, 5'b000_11, 5'b000_11};
    base = ev_q.size();
    btn_deb[0] = 1'b1;
    // 101 pressed edges: the first posts PRESS, the other 100 contain exactly 10 ticks.
    step(101);
    btn_deb[0] = 1'b0;
    step(20);
    checks++;
    if (ev_q.size() - base !== 5) begin
      failures++;
      $display("FAIL long_repeat_count got=%0d want=5", ev_q.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (ev_q[base+i] !== exp_ev[i]) begin
          failures++;
          $display("FAIL long_repeat_ev%0d got=%b want=%b", i, ev_q[base+i], exp_ev[i]);
        end
      end
      for (int i = 2; i < 5; i++) begin
        checks++;
        if (ts_q[base+i] - ts_q[base+i-1] !== 20) begin
          failures++;
          $display("FAIL repeat_spacing%0d got=%0d want=20", i, ts_q[base+i] - ts_q[base+i-1]);
        end
      end
    end
    after = ev_q.size();
    step(40);
    checks++;
    if (ev_q.size() !== after) begin
      failures++;
      $display("FAIL post_release_events got=%0d want=0", ev_q.size() - after);
    end
  endtask

  task automatic test_round_robin;
    int base;
    logic [4:0] exp_a [3];
    logic [4:0] exp_b [2];
    exp_a = '{5'b001_01, 5'b101_01, 5'b110_01};
    exp_b = '{5'b000_01, 5'b110_01};
    base = ev_q.size();
    btn_deb = 8'b0110_0010;
    step(8);
    checks++;
    if (ev_q.size() - base !== 3) begin
      failures++;
      $display("FAIL rr_a_count got=%0d want=3", ev_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ev_q[base+i] !== exp_a[i]) begin
          failures++;
          $display("FAIL rr_a_ev%0d got=%b want=%b", i, ev_q[base+i], exp_a[i]);
        end
      end
      checks++;
      if (ts_q[base+2] - ts_q[base] !== 2) begin
        failures++;
        $display("FAIL rr_a_back_to_back span got=%0d want=2", ts_q[base+2] - ts_q[base]);
      end
    end
    btn_deb = '0;
    step(3);
    base = ev_q.size();
    btn_deb = 8'b0100_0001;
    step(8);
    checks++;
    if (ev_q.size() - base !== 2) begin
      failures++;
      $display("FAIL rr_b_count got=%0d want=2", ev_q.size() - base);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ev_q[base+i] !== exp_b[i]) begin
          failures++;
          $display("FAIL rr_b_ev%0d got=%b want=%b", i, ev_q[base+i], exp_b[i]);
        end
      end
    end
    btn_deb = '0;
    step(3);
  endtask

  task automatic test_overflow;
    int base, ovf0;
    evt_ready = 1'b0;
    base = ev_q.size();
    ovf0 = ovf_cnt;
    for (int p = 0; p < 3; p++) begin
      btn_deb[3] = 1'b1;
      step(3);
      btn_deb[3] = 1'b0;
      step(2);
      checks++;
      if ({evt_valid, evt_id, evt_type} !== {1'b1, 3'd3, 2'b01}) begin
        failures++;
        $display("FAIL stall_hold_p%0d got=v%b id%0d t%b want=v1 id3 t01", p, evt_valid, evt_id, evt_type);
      end
    end
    checks++;
    if (ovf_cnt - ovf0 !== 1) begin
      failures++;
      $display("FAIL ovf_pulses got=%0d want=1", ovf_cnt - ovf0);
    end
    evt_ready = 1'b1;
    step(8);
    checks++;
    if (ev_q.size() - base !== 2) begin
      failures++;
      $display("FAIL ovf_delivered got=%0d want=2", ev_q.size() - base);
    end else begin
      checks++;
      if ({ev_q[base], ev_q[base+1]} !== {5'b011_01, 5'b011_01}) begin
        failures++;
        $display("FAIL ovf_events got=%b %b want=01101 01101", ev_q[base], ev_q[base+1]);
      end
    end
  endtask

  task automatic test_reset_midop;
    int base;
    evt_ready = 1'b0;
    btn_deb   = 8'b1001_0000;
    step(3);
    checks++;
    if (evt_valid !== 1'b1) begin
      failures++;
      $display("FAIL midop_preload valid got=%b want=1", evt_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_async_drop valid got=%b want=0", evt_valid);
    end
    btn_deb   = '0;
    evt_ready = 1'b1;
    step(3);
    @(negedge clk) rst_n = 1'b1;
    base = ev_q.size();
    step(30);
    checks++;
    if (ev_q.size() !== base || evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_stale got=%0d events valid=%b want=0 events valid=0", ev_q.size() - base, evt_valid);
    end
  endtask

  initial begin
    test_reset;
    test_press_latency;
    test_long_repeat;
    test_round_robin;
    test_overflow;
    test_reset_midop;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
